// File: rtl/clock_enable_gen.sv
// Clock-enable generator: one free-running master counter in the sysclk domain that produces
// power-of-two division enables and a CPU enable pair whose rate can be changed at run time.
module clock_enable_gen #(
    parameter int unsigned W       = 3,
    parameter int unsigned TURBO_W = 2
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic [TURBO_W-1:0] turbo,
    input  logic               cpu_wait,
    input  logic               resync,
    output logic [W-1:0]       cnt,
    output logic [W-1:0]       ce_div,
    output logic               cpu_ce,
    output logic               cpu_ce_n,
    output logic [TURBO_W-1:0] turbo_act
);

    logic [W-1:0]       cnt_q, cnt_d;
    logic [W-1:0]       ce_div_q, ce_div_d;
    logic [TURBO_W-1:0] turbo_act_q, turbo_act_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic               cpu_ce_n_q, cpu_ce_n_d;
    logic               boundary;
    int unsigned        turbo_clamp;
    int unsigned        cpu_div_exp;
    logic [W-1:0]       cpu_mask;
    logic [W-1:0]       cpu_half;

    // The turbo value is only swapped at a period boundary so no runt CPU period is produced.
    always_comb begin
        cnt_d       = resync ? '0 : cnt_q + W'(1);
        boundary    = (cnt_d == '0);
        turbo_act_d = boundary ? turbo : turbo_act_q;
    end

    always_comb begin
        ce_div_d = '0;
        for (int k = 0; k < W; k++) begin
            ce_div_d[k] = ((cnt_d & W'((1 << (k + 1)) - 1)) == '0);
        end
    end

    // CPU divide exponent uses the turbo value taking effect on this same edge.
    always_comb begin
        turbo_clamp = (32'(turbo_act_d) > W) ? W : 32'(turbo_act_d);
        cpu_div_exp = W - turbo_clamp;
        cpu_mask    = W'((1 << cpu_div_exp) - 1);
        cpu_half    = (cpu_div_exp == 0) ? '0 : W'(1 << (cpu_div_exp - 1));
        cpu_ce_d    = ((cnt_d & cpu_mask) == '0);
        cpu_ce_n_d  = (cpu_div_exp != 0) && ((cnt_d & cpu_mask) == cpu_half);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            ce_div_q    <= '0;
            turbo_act_q <= '0;
            cpu_ce_q    <= 1'b0;
            cpu_ce_n_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ce_div_q    <= ce_div_d;
            turbo_act_q <= turbo_act_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_ce_n_q  <= cpu_ce_n_d;
        end
    end

    // Wait drops the pulse outright; the CPU simply misses that slot.
    assign cpu_ce    = cpu_ce_q & ~cpu_wait;
    assign cpu_ce_n  = cpu_ce_n_q;
    assign cnt       = cnt_q;
    assign ce_div    = ce_div_q;
    assign turbo_act = turbo_act_q;

endmodule
